// File: rtl/circuit4_pipe_pkg.sv
// Shared types and helpers for the circuit4 add/compare/select/shift pipeline.
// trunc_chk works on a zero-extended MAX_W vector so one function serves every DATAWIDTH/OUTWIDTH.
package circuit_pkg;

  localparam int PIPE_LATENCY = 2;
  localparam int MAX_W        = 128;

  typedef struct packed {
    logic lt;
    logic eq;
  } flags_t;

  // Bits [dw-1:ow] must be all zero (unsigned) or all copies of bit ow-1 (signed).
  function automatic logic trunc_chk(input logic [MAX_W-1:0] shifted,
                                     input logic             signed_mode,
                                     input int               dw,
                                     input int               ow);
    logic [MAX_W-1:0] dw_mask;
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] msb_vec;
    logic [MAX_W-1:0] fill;
    dw_mask = ~({MAX_W{1'b1}} << dw);
    hi      = (shifted & dw_mask) >> ow;
    msb_vec = shifted >> (ow - 1);
    fill    = msb_vec[0] ? (dw_mask >> ow) : '0;
    return signed_mode ? (hi != fill) : (hi != '0);
  endfunction

endpackage

// File: rtl/circuit4_pipe_if.sv
// Operand/result bus for circuit4_pipe: operand side and result side, each with its own valid/ready pair.
// The slave modport is the pipeline's view; master is the source/consumer view.
interface circuit4_pipe_if #(
  parameter int DATAWIDTH = 64,
  parameter int OUTWIDTH  = 32
);
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUTWIDTH-1:0]  x;
  logic [OUTWIDTH-1:0]  z;
  logic                 x_trunc;
  logic                 z_trunc;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output a, b, c, in_valid, out_ready,
    input  in_ready, x, z, x_trunc, z_trunc, out_valid
  );

  modport slave (
    input  a, b, c, in_valid, out_ready,
    output in_ready, x, z, x_trunc, z_trunc, out_valid
  );
endinterface

// File: rtl/circuit4_pipe_stage1.sv
// Combinational first stage: sums/difference, lt/eq compare and the g/h select muxes.
// Only the compare honours SIGNED; the add/sub bits are identical in both modes.
module c4_stage1
  import circuit_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int SIGNED    = 0
) (
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_b,
  input  logic [DATAWIDTH-1:0] i_c,
  output logic [DATAWIDTH-1:0] o_g,
  output logic [DATAWIDTH-1:0] o_h,
  output flags_t               o_flags
);

  logic [DATAWIDTH-1:0] w_d;
  logic [DATAWIDTH-1:0] w_e;
  logic [DATAWIDTH-1:0] w_f;
  logic                 w_lt;
  logic                 w_eq;

  assign w_d  = i_a + i_b;
  assign w_e  = i_a + i_c;
  assign w_f  = i_a - i_b;
  assign w_lt = (SIGNED != 0) ? ($signed(w_d) < $signed(w_e)) : (w_d < w_e);
  assign w_eq = (w_d == w_e);

  assign o_g        = w_lt ? w_d : w_e;
  assign o_h        = w_eq ? o_g : w_f;
  assign o_flags.lt = w_lt;
  assign o_flags.eq = w_eq;

endmodule

// File: rtl/circuit4_pipe.sv
// Two-stage add/compare/select/shift pipeline with valid/ready on both sides.
// Stage 2 is the output register; it holds while out_valid && !out_ready and stalls stage 1 behind it.
module circuit4_pipe
  import circuit_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int OUTWIDTH  = 32,
  parameter int SHAMT     = 1,
  parameter int SIGNED    = 0
) (
  input logic            clk,
  input logic            rst,
  circuit4_pipe_if.slave bus
);

  logic [DATAWIDTH-1:0] w_g;
  logic [DATAWIDTH-1:0] w_h;
  flags_t               w_flags;

  logic                 r_s1_valid;
  logic [DATAWIDTH-1:0] r_g;
  logic [DATAWIDTH-1:0] r_h;
  flags_t               r_flags;

  logic                 r_out_valid;
  logic [OUTWIDTH-1:0]  r_x;
  logic [OUTWIDTH-1:0]  r_z;
  logic                 r_x_trunc;
  logic                 r_z_trunc;

  logic                 w_adv2;
  logic                 w_in_ready;
  logic                 w_accept;

  logic [DATAWIDTH-1:0] w_xs;
  logic [DATAWIDTH-1:0] w_zs;
  logic [DATAWIDTH-1:0] w_g_srl;
  logic [DATAWIDTH-1:0] w_g_sra;
  logic signed [DATAWIDTH-1:0] w_g_s;
  logic                 w_x_trunc;
  logic                 w_z_trunc;

  c4_stage1 #(
    .DATAWIDTH (DATAWIDTH),
    .SIGNED    (SIGNED)
  ) u_stage1 (
    .i_a     (bus.a),
    .i_b     (bus.b),
    .i_c     (bus.c),
    .o_g     (w_g),
    .o_h     (w_h),
    .o_flags (w_flags)
  );

  assign w_adv2     = r_s1_valid && (!r_out_valid || bus.out_ready);
  assign w_in_ready = !rst && (!r_s1_valid || w_adv2);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Separate signed copy keeps >>> arithmetic instead of being demoted by the mode mux.
  assign w_g_s   = r_g;
  assign w_g_sra = w_g_s >>> SHAMT;
  assign w_g_srl = r_g >> SHAMT;

  assign w_xs = r_flags.lt ? (r_h << SHAMT) : r_h;
  assign w_zs = !r_flags.eq ? r_g : ((SIGNED != 0) ? w_g_sra : w_g_srl);

  assign w_x_trunc = trunc_chk(MAX_W'(w_xs), SIGNED != 0, DATAWIDTH, OUTWIDTH);
  assign w_z_trunc = trunc_chk(MAX_W'(w_zs), SIGNED != 0, DATAWIDTH, OUTWIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_z         <= '0;
      r_x_trunc   <= 1'b0;
      r_z_trunc   <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_adv2) begin
        r_out_valid <= 1'b1;
        r_x         <= w_xs[OUTWIDTH-1:0];
        r_z         <= w_zs[OUTWIDTH-1:0];
        r_x_trunc   <= w_x_trunc;
        r_z_trunc   <= w_z_trunc;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Stage-1 payload needs no reset: it is only observed behind r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_g     <= w_g;
      r_h     <= w_h;
      r_flags <= w_flags;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.x         = r_x;
  assign bus.z         = r_z;
  assign bus.x_trunc   = r_x_trunc;
  assign bus.z_trunc   = r_z_trunc;

endmodule

// File: tb/tb_circuit4_pipe.sv
// Bench for circuit4_pipe: an unsigned and a signed instance share one stimulus stream,
// each checked against an arithmetic reference model through per-instance result queues.
module tb_circuit4_pipe;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] z;
    logic        xt;
    logic        zt;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t q0[$];
  res_t q1[$];

  always #5 clk = ~clk;

  circuit4_pipe_if #(.DATAWIDTH(64), .OUTWIDTH(32)) bus0 ();
  circuit4_pipe_if #(.DATAWIDTH(64), .OUTWIDTH(32)) bus1 ();

  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.c         = bus0.c;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.out_ready = bus0.out_ready;

  circuit4_pipe #(.DATAWIDTH(64), .OUTWIDTH(32), .SHAMT(1), .SIGNED(0)) dut_u (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  circuit4_pipe #(.DATAWIDTH(64), .OUTWIDTH(32), .SHAMT(1), .SIGNED(1)) dut_s (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  function automatic res_t ref_model(logic [63:0] a, logic [63:0] b, logic [63:0] c, bit sgn);
    logic [63:0] d, e, f, g, h, xs, zs;
    bit          lt, eq;
    longint      sx, sz;
    res_t        r;
    d  = a + b;
    e  = a + c;
    f  = a - b;
    lt = sgn ? ($signed(d) < $signed(e)) : (d < e);
    eq = (d == e);
    g  = lt ? d : e;
    h  = eq ? g : f;
    xs = lt ? h * 2 : h;
    if (!eq)               zs = g;
    else if (sgn && g[63]) zs = (g / 2) | 64'h8000_0000_0000_0000;
    else                   zs = g / 2;
    sx = xs;
    sz = zs;
    r.x = xs[31:0];
    r.z = zs[31:0];
    if (sgn) begin
      r.xt = (sx < longint'(32'sh8000_0000)) || (sx > longint'(32'sh7FFF_FFFF));
      r.zt = (sz < longint'(32'sh8000_0000)) || (sz > longint'(32'sh7FFF_FFFF));
    end else begin
      r.xt = (xs > 64'hFFFF_FFFF);
      r.zt = (zs > 64'hFFFF_FFFF);
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 15));
      2:       return -64'($urandom_range(1, 15));
      default: return {32'h0, $urandom};
    endcase
  endfunction

  task automatic set_ops();
    bus0.a = rnd64();
    bus0.b = rnd64();
    bus0.c = ($urandom_range(0, 3) == 0) ? bus0.b : rnd64();
  endtask

  // One clock: sample handshakes/outputs at the falling edge, queue accepted operands, return after the rising edge.
  task automatic tick(output bit acc, output bit ov0, output bit ov1, output res_t o0, output res_t o1);
    @(negedge clk);
    acc = bus0.in_valid && bus0.in_ready;
    ov0 = bus0.out_valid;
    ov1 = bus1.out_valid;
    o0  = {bus0.x, bus0.z, bus0.x_trunc, bus0.z_trunc};
    o1  = {bus1.x, bus1.z, bus1.x_trunc, bus1.z_trunc};
    if (acc) begin
      q0.push_back(ref_model(bus0.a, bus0.b, bus0.c, 1'b0));
      q1.push_back(ref_model(bus0.a, bus0.b, bus0.c, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus0.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_u: got %b want 0", bus0.in_ready); end
    n_cmp++; if (bus1.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_s: got %b want 0", bus1.in_ready); end
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_u: got %b want 0", bus0.out_valid); end
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_s: got %b want 0", bus1.out_valid); end
    n_cmp++; if ({bus0.x, bus0.z, bus0.x_trunc, bus0.z_trunc} !== 66'h0) begin
      n_bad++; $display("FAIL reset_outputs_u: got x=%h z=%h xt=%b zt=%b want all 0", bus0.x, bus0.z, bus0.x_trunc, bus0.z_trunc);
    end
    n_cmp++; if ({bus1.x, bus1.z, bus1.x_trunc, bus1.z_trunc} !== 66'h0) begin
      n_bad++; $display("FAIL reset_outputs_s: got x=%h z=%h xt=%b zt=%b want all 0", bus1.x, bus1.z, bus1.x_trunc, bus1.z_trunc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [63:0] a, b, c;
    res_t        exp;
    bit          sel;
  } vec_t;

  task automatic test_directed();
    vec_t vt[4];
    bit   acc, ov0, ov1;
    res_t o0, o1, got;
    vt[0] = {64'd5, 64'd3, 64'd4, 32'd4, 32'd8, 1'b0, 1'b0, 1'b0};
    vt[1] = {64'd1, 64'd2, 64'd2, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0};
    vt[2] = {64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0};
    vt[3] = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.a = vt[i].a; bus0.b = vt[i].b; bus0.c = vt[i].c;
      bus0.in_valid = 1'b1;
      tick(acc, ov0, ov1, o0, o1);
      bus0.in_valid = 1'b0;
      n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL dir%0d_accept: got %b want 1", i, acc); end
      tick(acc, ov0, ov1, o0, o1);
      n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early_valid: got %b want 0 one edge after accept", i, ov0); end
      tick(acc, ov0, ov1, o0, o1);
      n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL dir%0d_latency: out_valid got %b want 1 two edges after accept", i, ov0); end
      got = vt[i].sel ? o1 : o0;
      n_cmp++; if (got !== vt[i].exp) begin
        n_bad++; $display("FAIL dir%0d_result: got x=%h z=%h xt=%b zt=%b want x=%h z=%h xt=%b zt=%b",
                          i, got.x, got.z, got.xt, got.zt, vt[i].exp.x, vt[i].exp.z, vt[i].exp.xt, vt[i].exp.zt);
      end
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic test_backpressure();
    bit   acc, ov0, ov1, have_hold;
    res_t o0, o1, held, e0, e1;
    int   nacc, ndrn, first, last;
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    set_ops();
    nacc = 0; have_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(acc, ov0, ov1, o0, o1);
      if (ov0) begin
        if (!have_hold) begin
          held = o0; have_hold = 1'b1;
        end else begin
          n_cmp++; if (o0 !== held) begin n_bad++; $display("FAIL bp_hold_stable: got %h want %h", o0, held); end
        end
      end
      if (acc) begin nacc++; set_ops(); end
    end
    n_cmp++; if (nacc !== 2) begin n_bad++; $display("FAIL bp_accepts_while_stalled: got %0d want 2", nacc); end
    n_cmp++; if (bus0.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b want 0", bus0.in_ready); end
    n_cmp++; if (q0.size() == 0 || held !== q0[0]) begin
      n_bad++; $display("FAIL bp_held_value: got %h want first queued result (queue size %0d)", held, q0.size());
    end
    bus0.out_ready = 1'b1;
    ndrn = 0; first = -1; last = -1;
    for (int i = 0; i < 40 && ndrn < 4; i++) begin
      tick(acc, ov0, ov1, o0, o1);
      if (acc) begin
        nacc++;
        if (nacc >= 4) bus0.in_valid = 1'b0;
        else set_ops();
      end
      if (ov0) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL bp_unexpected_result: got %h with empty reference queue", o0);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front();
          n_cmp++; if (o0 !== e0) begin n_bad++; $display("FAIL bp_order_u: got %h want %h", o0, e0); end
          n_cmp++; if (o1 !== e1) begin n_bad++; $display("FAIL bp_order_s: got %h want %h", o1, e1); end
        end
        ndrn++;
        if (first < 0) first = i;
        last = i;
      end
    end
    bus0.in_valid = 1'b0;
    n_cmp++; if (ndrn !== 4) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 4", ndrn); end
    n_cmp++; if (last - first !== 3) begin n_bad++; $display("FAIL bp_one_per_cycle: span got %0d want 3", last - first); end
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset_midflight();
    bit   acc, ov0, ov1, seen;
    res_t o0, o1, e0, e1;
    int   nacc;
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    set_ops();
    nacc = 0;
    for (int i = 0; i < 10 && nacc < 2; i++) begin
      tick(acc, ov0, ov1, o0, o1);
      if (acc) begin nacc++; set_ops(); end
    end
    bus0.in_valid = 1'b0;
    tick(acc, ov0, ov1, o0, o1);
    n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL rmid_inflight: out_valid got %b want 1 before reset", ov0); end
    rst = 1'b1;
    tick(acc, ov0, ov1, o0, o1);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    n_cmp++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_out_valid: got %b/%b want 0/0", bus0.out_valid, bus1.out_valid);
    end
    n_cmp++; if ({bus0.x, bus0.z, bus1.x, bus1.z} !== 128'h0) begin
      n_bad++; $display("FAIL rmid_xz: got %h %h %h %h want 0", bus0.x, bus0.z, bus1.x, bus1.z);
    end
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc, ov0, ov1, o0, o1);
      n_cmp++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin n_bad++; $display("FAIL rmid_stale_%0d: out_valid got %b/%b want 0/0", i, ov0, ov1); end
    end
    bus0.in_valid = 1'b1;
    set_ops();
    tick(acc, ov0, ov1, o0, o1);
    bus0.in_valid = 1'b0;
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL rmid_accept: got %b want 1", acc); end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick(acc, ov0, ov1, o0, o1);
      if (ov0 && q0.size() > 0 && q1.size() > 0) begin
        seen = 1'b1;
        e0 = q0.pop_front(); e1 = q1.pop_front();
        n_cmp++; if (o0 !== e0) begin n_bad++; $display("FAIL rmid_first_u: got %h want %h", o0, e0); end
        n_cmp++; if (o1 !== e1) begin n_bad++; $display("FAIL rmid_first_s: got %h want %h", o1, e1); end
      end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmid_timeout: got no result want one within 5 cycles"); end
    q0.delete();
    q1.delete();
  endtask

  task automatic test_random();
    bit   acc, ov0, ov1, prev_hold, rdy;
    res_t o0, o1, p0, p1, e0, e1;
    int   errs_before;
    prev_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus0.in_valid  = ($urandom_range(0, 3) != 0);
      bus0.out_ready = ($urandom_range(0, 9) < 7);
      set_ops();
      rdy = bus0.out_ready;
      tick(acc, ov0, ov1, o0, o1);
      errs_before = n_bad;
      n_cmp++; if (ov1 !== ov0) begin n_bad++; $display("FAIL rnd_valid_agree @%0d: signed %b unsigned %b", i, ov1, ov0); end
      if (prev_hold) begin
        n_cmp++; if (o0 !== p0 || o1 !== p1) begin n_bad++; $display("FAIL rnd_hold @%0d: got %h/%h want %h/%h", i, o0, o1, p0, p1); end
      end
      if (ov0 && rdy) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rnd_extra_result @%0d: got %h with empty reference queue", i, o0);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front();
          n_cmp++; if (o0 !== e0) begin n_bad++; $display("FAIL rnd_result_u @%0d: got %h want %h", i, o0, e0); end
          n_cmp++; if (o1 !== e1) begin n_bad++; $display("FAIL rnd_result_s @%0d: got %h want %h", i, o1, e1); end
        end
      end
      prev_hold = ov0 && !rdy;
      p0 = o0;
      p1 = o1;
      if (n_bad - errs_before > 0 && n_bad > 20) break;
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 10 && q0.size() > 0; i++) begin
      tick(acc, ov0, ov1, o0, o1);
      if (ov0 && q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front(); e1 = q1.pop_front();
        n_cmp++; if (o0 !== e0) begin n_bad++; $display("FAIL rnd_drain_u: got %h want %h", o0, e0); end
        n_cmp++; if (o1 !== e1) begin n_bad++; $display("FAIL rnd_drain_s: got %h want %h", o1, e1); end
      end
    end
    n_cmp++; if (q0.size() != 0) begin n_bad++; $display("FAIL rnd_lost_results: got %0d outstanding want 0", q0.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus0.a = '0;
    bus0.b = '0;
    bus0.c = '0;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, %0d compared so far", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
